fir_decim_buffer: RTL

FIR_DECIM_BUFFER -- requirements
Module: fir_decim_buffer

---
 rtl/fir_decim_buffer.sv | 107 ++++++++++
 1 files changed

// File: rtl/fir_decim_buffer.sv
// Decimating averager for an FIR output stream: every N input samples are
// summed and truncated to their mean, then queued in a D-entry FIFO for a ready/valid consumer.
module fir_decim_buffer #(
    parameter int DW         = 16,
    parameter int DECIM_LOG2 = 2,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DW-1:0]         in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DW-1:0]         out_data,
    output logic [DEPTH_LOG2:0]   fifo_count,
    output logic                  overflow
);

    localparam int AW = DW + DECIM_LOG2;
    localparam int D  = 1 << DEPTH_LOG2;

    localparam logic [DECIM_LOG2-1:0] PHASE_LAST = {DECIM_LOG2{1'b1}};
    localparam logic [DEPTH_LOG2:0]   COUNT_FULL = (DEPTH_LOG2 + 1)'(D);
    localparam logic [DEPTH_LOG2:0]   COUNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
    localparam logic [DECIM_LOG2-1:0] PHASE_ONE  = DECIM_LOG2'(1);

    // Mean of N samples: the sum is AW bits wide, so dropping the low bits
    // leaves exactly DW bits and no overflow can occur.
    function automatic logic [DW-1:0] trunc_avg(input logic [AW-1:0] sum);
        trunc_avg = sum[AW-1:DECIM_LOG2];
    endfunction

    logic [AW-1:0]         acc_p0;
    logic [DECIM_LOG2-1:0] phase_p0;
    logic [AW-1:0]         sum_p0;
    logic [DW-1:0]         res_p0;
    logic                  vld_p0;

    logic [DW-1:0]         mem [D];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic                  full;
    logic                  pop;
    logic                  push;

    // ---- stage 0: accumulate and decimate ----
    assign sum_p0 = acc_p0 + {{DECIM_LOG2{1'b0}}, in_data};
    assign res_p0 = trunc_avg(sum_p0);
    assign vld_p0 = in_valid && (phase_p0 == PHASE_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_p0   <= '0;
            phase_p0 <= '0;
        end else if (in_valid) begin
            if (phase_p0 == PHASE_LAST) begin
                acc_p0   <= '0;
                phase_p0 <= '0;
            end else begin
                acc_p0   <= sum_p0;
                phase_p0 <= phase_p0 + PHASE_ONE;
            end
        end
    end

    // ---- stage 1: circular FIFO ----
    assign full       = (count == COUNT_FULL);
    assign out_valid  = (count != '0);
    assign pop        = out_valid && out_ready;
    // A full FIFO still takes the new result when the head leaves this cycle.
    assign push       = vld_p0 && (!full || pop);
    assign out_data   = mem[rd_ptr];
    assign fifo_count = count;

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= res_p0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
            if (vld_p0 && !push) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule
